// File: rtl/wb_hyperram_split_pkg.sv
// Shared types and constants for the Wishbone HyperRAM channel splitter.
// Imported by the splitter top and its watchdog.
package wb_split_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } split_state_e;

  localparam logic [31:0] ERR_UNMAPPED = 32'hBAD0_ADD0;
  localparam logic [31:0] ERR_TIMEOUT  = 32'hDEAD_BEEF;

  localparam int STAT_CH_LSB  = 0;
  localparam int STAT_CH_W    = 7;
  localparam int STAT_IRQ_BIT = 7;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  function automatic logic [31:0] pack_status(input logic [STAT_CNT_W-1:0] cnt,
                                              input logic                  irq,
                                              input logic [STAT_CH_W-1:0]  ch);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    w[STAT_IRQ_BIT]               = irq;
    w[STAT_CH_LSB +: STAT_CH_W]   = ch;
    return w;
  endfunction

endpackage

// File: rtl/wb_hyperram_split_if.sv
// Upstream Wishbone slave port of the splitter (Caravel user-area bus side).
interface wb_hyperram_split_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_hyperram_split_watchdog.sv
// Channel-wait watchdog: counts BUSY cycles, pulses at the limit, and keeps a
// saturating timeout count, the last timed-out channel and a sticky irq.
module wb_split_watchdog
  import wb_split_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  busy,
  input  logic                  ack_hit,
  input  logic [2:0]            ch_idx,
  input  logic                  clear,
  output logic                  tc,
  output logic                  irq,
  output logic [STAT_CNT_W-1:0] evt_cnt,
  output logic [STAT_CH_W-1:0]  last_ch
);

  localparam logic [15:0] TC_VAL = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;

  // A channel ack in the terminal cycle takes precedence over the timeout.
  assign tc = busy && !ack_hit && (wait_cnt == TC_VAL);

  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      irq     <= 1'b0;
      evt_cnt <= '0;
      last_ch <= '0;
    end else if (tc) begin
      irq     <= 1'b1;
      evt_cnt <= (evt_cnt == '1) ? evt_cnt : evt_cnt + 1'b1;
      last_ch <= {4'b0, ch_idx};
    end
  end

endmodule

// File: rtl/wb_hyperram_split.sv
// Wishbone splitter fanning one upstream slave out to NUM_CH HyperRAM channels.
// Define WB_SPLIT_TIMEOUT_EN to add the channel watchdog, status register and irq.
module wb_hyperram_split
  import wb_split_pkg::*;
#(
  parameter int          NUM_CH         = 2,
  parameter int          CH_ADDR_BITS   = 23,
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  wb_hyperram_split_if.slave       wbs,
  output logic [NUM_CH-1:0]        ch_cyc_o,
  output logic [NUM_CH-1:0]        ch_stb_o,
  output logic                     ch_we_o,
  output logic [3:0]               ch_sel_o,
  output logic [31:0]              ch_adr_o,
  output logic [31:0]              ch_dat_o,
  input  logic [NUM_CH-1:0]        ch_ack_i,
  input  logic [32*NUM_CH-1:0]     ch_dat_i,
  output logic                     irq_o
);

  localparam int               IDX_W   = $clog2(NUM_CH + 1);
  localparam logic [IDX_W-1:0] NUM_IDX = IDX_W'(NUM_CH);
  localparam logic [31:0]      LO_MASK = (32'h1 << CH_ADDR_BITS) - 32'h1;
  // Bits between the channel index and the base nibble must be zero.
  localparam logic [31:0]      HI_MASK = 32'h0FFF_FFFF &
                                         ~((32'h1 << (CH_ADDR_BITS + IDX_W)) - 32'h1);

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("wb_hyperram_split: NUM_CH must be in 1..8");
  end
  if (CH_ADDR_BITS + IDX_W > 28) begin : g_bad_window
    $error("wb_hyperram_split: CH_ADDR_BITS + IDX_W exceeds 28");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_hyperram_split: TIMEOUT_CYCLES must be in 1..65535");
  end

  split_state_e state, state_nx;

  logic [31:0]       adr_q, dat_q, rdat_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [NUM_CH-1:0] ch_oh_q;

  logic [IDX_W-1:0]  req_idx;
  logic              req_valid, req_mapped, req_is_ch, req_is_stat;
  logic [NUM_CH-1:0] req_oh;
  logic              accept, ack_hit, tc;
  logic [31:0]       ch_rdat, accept_dat;

  always_comb begin
    req_valid  = wbs.wbs_cyc_i && wbs.wbs_stb_i;
    req_idx    = wbs.wbs_adr_i[CH_ADDR_BITS +: IDX_W];
    req_mapped = (wbs.wbs_adr_i[31:28] == BASE_ADDR[31:28]) &&
                 ((wbs.wbs_adr_i & HI_MASK) == 32'h0);
    req_is_ch  = req_mapped && (req_idx < NUM_IDX);
    req_oh     = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      req_oh[n] = req_is_ch && (req_idx == IDX_W'(n));
    end
  end

  assign accept  = (state == IDLE) && req_valid;
  assign ack_hit = (state == BUSY) && |(ch_ack_i & ch_oh_q);

  always_comb begin
    ch_rdat = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_oh_q[n]) ch_rdat = ch_rdat | ch_dat_i[32*n +: 32];
    end
  end

`ifdef WB_SPLIT_TIMEOUT_EN
  logic                  stat_clear;
  logic                  wd_irq;
  logic [STAT_CNT_W-1:0] wd_cnt;
  logic [STAT_CH_W-1:0]  wd_last;
  logic [2:0]            ch_enc;

  assign req_is_stat = req_mapped && (req_idx == NUM_IDX);
  assign stat_clear  = accept && req_is_stat && wbs.wbs_we_i;
  assign accept_dat  = req_is_stat ? (wbs.wbs_we_i ? 32'h0 : pack_status(wd_cnt, wd_irq, wd_last))
                                   : ERR_UNMAPPED;
  assign irq_o       = wd_irq;

  always_comb begin
    ch_enc = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_oh_q[n]) ch_enc = 3'(n);
    end
  end

  wb_split_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .busy    (state == BUSY),
    .ack_hit (ack_hit),
    .ch_idx  (ch_enc),
    .clear   (stat_clear),
    .tc      (tc),
    .irq     (wd_irq),
    .evt_cnt (wd_cnt),
    .last_ch (wd_last)
  );
`else
  assign req_is_stat = 1'b0;
  assign accept_dat  = ERR_UNMAPPED;
  assign tc          = 1'b0;
  assign irq_o       = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    wbs.wbs_ack_o = 1'b0;
    wbs.wbs_dat_o = '0;
    unique case (state)
      IDLE: if (req_valid) state_nx = req_is_ch ? BUSY : RESP;
      BUSY: if (ack_hit || tc) state_nx = RESP;
      RESP: begin
        state_nx      = IDLE;
        wbs.wbs_ack_o = 1'b1;
        wbs.wbs_dat_o = rdat_q;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch and response capture; the one-hot strobe is only set in BUSY.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      adr_q   <= '0;
      dat_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      rdat_q  <= '0;
      ch_oh_q <= '0;
    end else if (accept) begin
      adr_q   <= wbs.wbs_adr_i & LO_MASK;
      dat_q   <= wbs.wbs_dat_i;
      we_q    <= wbs.wbs_we_i;
      sel_q   <= wbs.wbs_sel_i;
      ch_oh_q <= req_oh;
      rdat_q  <= req_is_ch ? 32'h0 : accept_dat;
    end else if (ack_hit) begin
      rdat_q  <= ch_rdat;
      ch_oh_q <= '0;
    end else if (tc) begin
      rdat_q  <= ERR_TIMEOUT;
      ch_oh_q <= '0;
    end
  end

  assign ch_cyc_o = ch_oh_q;
  assign ch_stb_o = ch_oh_q;
  assign ch_we_o  = we_q;
  assign ch_sel_o = sel_q;
  assign ch_adr_o = adr_q;
  assign ch_dat_o = dat_q;

endmodule

// File: tb/tb_wb_hyperram_split.sv
// Randomized self-checking bench for wb_hyperram_split against a
// transaction-level model; timeout cases run when WB_SPLIT_TIMEOUT_EN is defined.
module tb_wb_hyperram_split;
  import wb_split_pkg::*;

  localparam int NUM_CH = 2;
  localparam int CAB    = 23;
  localparam int IDX_W  = 2;
  localparam int T      = 16;
  localparam int NEVER  = 32'h7fff_ffff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_hyperram_split_if bus();

  logic [NUM_CH-1:0]    ch_cyc, ch_stb, ch_ack;
  logic                 ch_we, irq;
  logic [3:0]           ch_sel;
  logic [31:0]          ch_adr, ch_wdat;
  logic [32*NUM_CH-1:0] ch_rdat;

  wb_hyperram_split #(
    .NUM_CH         (NUM_CH),
    .CH_ADDR_BITS   (CAB),
    .BASE_ADDR      (32'h3000_0000),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .ch_cyc_o (ch_cyc),
    .ch_stb_o (ch_stb),
    .ch_we_o  (ch_we),
    .ch_sel_o (ch_sel),
    .ch_adr_o (ch_adr),
    .ch_dat_o (ch_wdat),
    .ch_ack_i (ch_ack),
    .ch_dat_i (ch_rdat),
    .irq_o    (irq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the transaction in flight, in cycles relative to acceptance.
  int          cyc       = 0;
  bit          chk_en    = 1'b0;
  int          m_c0      = 0;
  int          m_ch      = -1;
  int          m_ack_rel = -1;
  int          m_stb_end = 0;
  int          m_kill    = NEVER;
  int          zero_cyc  = -1;
  logic [31:0] m_adr, m_dat, m_rdat;
  logic        m_we;
  logic [3:0]  m_sel;
  int          irq_from  = NEVER;
  int          to_cnt    = 0;
  int          to_ch     = 0;

  // Observations for the literal checks.
  int          ack_cnt;
  int          last_ack_cyc;
  logic [31:0] last_ack_dat;
  logic [31:0] stb_or, seen_adr, seen_dat;
  logic [3:0]  seen_sel;
  logic        seen_we;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin : compare
    int          rel;
    logic [31:0] exp_stb;
    logic        exp_ack, exp_irq;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (chk_en) begin
        rel     = cyc - m_c0;
        exp_stb = (m_ch >= 0 && rel >= 1 && rel <= m_stb_end && cyc < m_kill)
                  ? (32'h1 << m_ch) : 32'h0;
        exp_ack = (m_ack_rel > 0 && rel == m_ack_rel && cyc < m_kill);
`ifdef WB_SPLIT_TIMEOUT_EN
        exp_irq = (cyc >= irq_from);
`else
        exp_irq = 1'b0;
`endif
        check("ch_stb", 32'(ch_stb), exp_stb);
        check("ch_cyc", 32'(ch_cyc), exp_stb);
        check("wbs_ack", 32'(bus.wbs_ack_o), 32'(exp_ack));
        check("irq", 32'(irq), 32'(exp_irq));
        if (exp_ack) check("wbs_dat", bus.wbs_dat_o, m_rdat);
        if (exp_stb != 0) begin
          check("ch_adr", ch_adr, m_adr & ((32'h1 << CAB) - 1));
          check("ch_we", 32'(ch_we), 32'(m_we));
          check("ch_sel", 32'(ch_sel), 32'(m_sel));
          check("ch_dat", ch_wdat, m_dat);
        end
        if (cyc == zero_cyc) begin
          check("rst_adr", ch_adr, 32'h0);
          check("rst_wdat", ch_wdat, 32'h0);
          check("rst_sel", 32'(ch_sel), 32'h0);
          check("rst_we", 32'(ch_we), 32'h0);
          check("rst_dat_o", bus.wbs_dat_o, 32'h0);
        end
        if (bus.wbs_ack_o) begin
          ack_cnt++;
          last_ack_cyc = cyc;
          last_ack_dat = bus.wbs_dat_o;
        end
        stb_or = stb_or | 32'(ch_stb);
        if (ch_stb != 0) begin
          seen_adr = ch_adr;
          seen_dat = ch_wdat;
          seen_sel = ch_sel;
          seen_we  = ch_we;
        end
      end
    end
  end

  task automatic bus_idle();
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
    bus.wbs_sel_i = 4'h0;
    bus.wbs_adr_i = 32'h0;
    bus.wbs_dat_i = 32'h0;
    ch_ack        = '0;
  endtask

  // lat: channel ack offset from acceptance (0 = channel never acks).
  // rst_at: offset at which reset is pulsed mid-transaction (0 = none).
  task automatic do_txn(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                        input logic [31:0] wdat, input int lat, input logic [31:0] rdat,
                        input int rst_at);
    int          idx, ch, ack_rel;
    bit          mapped;
    logic [31:0] exp_d;
    @(negedge clk);
    idx    = int'((adr >> CAB) & ((32'h1 << IDX_W) - 1));
    mapped = (adr[31:28] == 4'h3) && (((adr & 32'h0FFF_FFFF) >> (CAB + IDX_W)) == 0);
    ch     = -1;
    if (mapped && idx < NUM_CH) begin
      ch = idx;
`ifdef WB_SPLIT_TIMEOUT_EN
      if (lat > 0 && lat <= T) begin
        ack_rel = lat + 1;
        exp_d   = rdat;
      end else begin
        ack_rel = T + 1;
        exp_d   = ERR_TIMEOUT;
        to_cnt  = (to_cnt < 255) ? to_cnt + 1 : 255;
        to_ch   = ch;
        if (irq_from == NEVER) irq_from = cyc + T + 1;
      end
`else
      ack_rel = lat + 1;
      exp_d   = rdat;
`endif
    end
`ifdef WB_SPLIT_TIMEOUT_EN
    else if (mapped && idx == NUM_CH) begin
      ack_rel = 1;
      if (we) begin
        exp_d    = 32'h0;
        irq_from = NEVER;
        to_cnt   = 0;
        to_ch    = 0;
      end else begin
        exp_d = {16'h0, 8'(to_cnt), (irq_from != NEVER), 7'(to_ch)};
      end
    end
`endif
    else begin
      ack_rel = 1;
      exp_d   = ERR_UNMAPPED;
    end
    m_c0      = cyc;
    m_ch      = ch;
    m_ack_rel = ack_rel;
    m_stb_end = (ch >= 0) ? ack_rel - 1 : 0;
    m_kill    = NEVER;
    m_adr     = adr;
    m_we      = we;
    m_sel     = sel;
    m_dat     = wdat;
    m_rdat    = exp_d;
    ack_cnt      = 0;
    last_ack_cyc = -1;
    last_ack_dat = 32'hx;
    stb_or       = 32'h0;
    seen_adr     = 32'hx;
    seen_dat     = 32'hx;
    seen_sel     = 4'hx;
    seen_we      = 1'bx;
    bus.wbs_cyc_i = 1'b1;
    bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i  = we;
    bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr;
    bus.wbs_dat_i = wdat;
    for (int t = 1; t <= ack_rel; t++) begin
      @(negedge clk);
      if (t == rst_at) begin
        rst      = 1'b1;
        bus_idle();
        m_kill   = cyc + 1;
        zero_cyc = cyc + 1;
        irq_from = NEVER;
        to_cnt   = 0;
        to_ch    = 0;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      ch_ack  = NUM_CH'($urandom);
      ch_rdat = {$urandom, $urandom};
      if (ch >= 0) begin
        ch_ack[ch]           = (t == lat);
        ch_rdat[32*ch +: 32] = rdat;
      end
      if (t == ack_rel) bus_idle();
    end
  endtask

  initial begin : stimulus
    logic [31:0] adr;
    int          lat;
    bus_idle();
    ch_rdat = '0;
    rst     = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_stb", 32'(ch_stb), 32'h0);
    check("reset_ack", 32'(bus.wbs_ack_o), 32'h0);
    check("reset_dat", bus.wbs_dat_o, 32'h0);
    check("reset_adr", ch_adr, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // ch1 read, ack 3 cycles after strobe
    do_txn(32'h3080_0010, 1'b0, 4'hF, 32'h0, 3, 32'h1234_5678, 0);
    check("rd_dat", last_ack_dat, 32'h1234_5678);
    check("rd_ack_cycle", 32'(last_ack_cyc - m_c0), 32'd4);
    check("rd_stb", stb_or, 32'h2);
    check("rd_adr", seen_adr, 32'h10);
    check("rd_ack_count", 32'(ack_cnt), 32'd1);

    // ch0 write with partial selects
    do_txn(32'h3000_0004, 1'b1, 4'b0011, 32'hA5A5_A5A5, 2, 32'h0, 0);
    check("wr_stb", stb_or, 32'h1);
    check("wr_sel", 32'(seen_sel), 32'h3);
    check("wr_dat", seen_dat, 32'hA5A5_A5A5);
    check("wr_we", 32'(seen_we), 32'h1);

    // Unmapped reads
    do_txn(32'h3800_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 0);
    check("unm1_dat", last_ack_dat, 32'hBAD0_ADD0);
    check("unm1_cycle", 32'(last_ack_cyc - m_c0), 32'd1);
    check("unm1_stb", stb_or, 32'h0);
    do_txn(32'h4000_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 0);
    check("unm2_dat", last_ack_dat, 32'hBAD0_ADD0);
    check("unm2_cycle", 32'(last_ack_cyc - m_c0), 32'd1);

`ifdef WB_SPLIT_TIMEOUT_EN
    do_txn(32'h3000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, 0);
    check("to_dat", last_ack_dat, 32'hDEAD_BEEF);
    check("to_cycle", 32'(last_ack_cyc - m_c0), 32'd17);
    @(negedge clk);
    check("to_irq", 32'(irq), 32'h1);
    do_txn(32'h3100_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 0);
    check("stat_rd", last_ack_dat, 32'h0000_0180);
    do_txn(32'h3100_0000, 1'b1, 4'hF, 32'hFFFF_FFFF, 1, 32'h0, 0);
    check("stat_wr_dat", last_ack_dat, 32'h0);
    @(negedge clk);
    check("stat_wr_irq", 32'(irq), 32'h0);
`else
    do_txn(32'h3100_0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 0);
    check("stat_unm_dat", last_ack_dat, 32'hBAD0_ADD0);
`endif

    // Reset while BUSY on ch1, then a normal ch1 read
    do_txn(32'h3080_0100, 1'b0, 4'hF, 32'h1111_2222, 10, 32'h0, 3);
    check("mid_rst_stb", 32'(ch_stb), 32'h0);
    check("mid_rst_adr", ch_adr, 32'h0);
    check("mid_rst_ack", 32'(bus.wbs_ack_o), 32'h0);
    do_txn(32'h3080_0040, 1'b0, 4'hF, 32'h0, 2, 32'hCAFE_0001, 0);
    check("post_rst_dat", last_ack_dat, 32'hCAFE_0001);
    check("post_rst_cycle", 32'(last_ack_cyc - m_c0), 32'd3);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       adr = 32'h3000_0000 | ($urandom & 32'h007F_FFFF);
        1:       adr = 32'h3080_0000 | ($urandom & 32'h007F_FFFF);
        2:       adr = 32'h3000_0000 | ($urandom & 32'h00FF_FFFF);
        3:       adr = 32'h3100_0000 | ($urandom & 32'h007F_FFFF);
        4: begin
          int top;
          top = $urandom_range(0, 14);
          if (top >= 3) top++;
          adr = {4'(top), 28'($urandom)};
        end
        default: adr = 32'h3000_0000 | (32'h1 << $urandom_range(25, 27)) | ($urandom & 32'h00FF_FFFF);
      endcase
`ifdef WB_SPLIT_TIMEOUT_EN
      lat = $urandom_range(0, 20);
`else
      lat = $urandom_range(1, 12);
`endif
      do_txn(adr, 1'($urandom), 4'($urandom), $urandom, lat, $urandom, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
